// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - EX-stage multiply/divide unit operand, control and HI/LO bundle
// The pipeline side drives the master modport; mult_div_unit takes the slave modport.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             flush;
  logic             hilo_read;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, op, A, B, flush, hilo_read,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, A, B, flush, hilo_read,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
// One product/quotient bit per cycle on magnitudes, sign fix-up in a final cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  mult_div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               div_q, div_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               signed_op;
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand magnitudes; op[0]==0 selects the signed variants (MULT, DIV).
  assign signed_op = ~bus.op[0];
  assign neg_a     = signed_op & bus.A[WIDTH-1];
  assign neg_b     = signed_op & bus.B[WIDTH-1];
  assign abs_a     = neg_a ? (~bus.A + 1'b1) : bus.A;
  assign abs_b     = neg_b ? (~bus.B + 1'b1) : bus.B;

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, then shift right.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

  // Divide: acc = {remainder, dividend/quotient}; shift left one bit and trial-subtract.
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd_q};

  assign prod_fix  = (sa_q ^ sb_q) ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix   = (sa_q ^ sb_q) ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem_fix   = sa_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    div_d   = div_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          if (!bus.op[2]) begin
            div_d   = bus.op[1];
            sa_d    = neg_a;
            sb_d    = neg_b;
            opnd_d  = bus.op[1] ? abs_b : abs_a;
            acc_d   = bus.op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
            count_d = CW'(WIDTH - 1);
            state_d = RUN;
          end else if (bus.op == 3'd4) begin
            hi_d = bus.A;
          end else if (bus.op == 3'd5) begin
            lo_d = bus.A;
          end
        end
      end

      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          if (div_q) begin
            acc_d = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          if (count_q == '0) begin
            state_d = FIX;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
      end

      FIX: begin
        state_d = IDLE;
        if (!bus.flush) begin
          done_d = 1'b1;
          if (div_q) begin
            // Divide by zero leaves remainder = |A|, so rem_fix restores the original A.
            hi_d = rem_fix;
            lo_d = (opnd_q == '0) ? {WIDTH{1'b1}} : quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
  assign bus.stall = bus.busy & (bus.start | bus.hilo_read);

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit with directed vectors
module tb_mult_div_unit;

  localparam int W = 32;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_NOP   = 3'd7;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_hi"}, {32'd0, bus.hi}, {32'd0, e.hi});
        check({e.name, "_lo"}, {32'd0, bus.lo}, {32'd0, e.lo});
      end
    end
  end

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int cycles;
    bit busy_ok;
    sb_q.push_back('{name, eh, el});
    bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = OP_NOP;
    cycles  = 1;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && cycles < 60) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      cycles++;
    end
    check({name, "_latency"}, 64'(cycles), 64'd34);
    check({name, "_busy_span"}, {63'd0, busy_ok}, 64'd1);
    check({name, "_busy_in_done"}, {63'd0, bus.busy}, 64'd0);
  endtask

  task automatic move_to(input logic [2:0] op, input logic [31:0] v);
    bus.start = 1'b1; bus.op = op; bus.A = v;
    @(negedge clk);
    bus.start = 1'b0; bus.op = OP_NOP;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    bit stall_ok;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = OP_NOP; bus.A = '0; bus.B = '0;
    bus.flush = 1'b0; bus.hilo_read = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hi",    {32'd0, bus.hi}, 64'd0);
    check("reset_lo",    {32'd0, bus.lo}, 64'd0);
    check("reset_busy",  {63'd0, bus.busy}, 64'd0);
    check("reset_done",  {63'd0, bus.done}, 64'd0);
    check("reset_stall", {63'd0, bus.stall}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mult_neg3x5",    OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("multu_max",      OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_negxneg",   OP_MULT,  32'hFFFFFFF9, 32'hFFFFFFFA, 32'h00000000, 32'h0000002A);
    run_op("div_neg7by2",    OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_100by0",    OP_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF);
    run_op("div_neg5by0",    OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("div_min_by_m1",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("divu_big",       OP_DIVU,  32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999);

    // Back-to-back: MFHI stalls while busy, a second start waits for IDLE.
    sb_q.push_back('{"mult_6x7", 32'h0, 32'd42});
    bus.start = 1'b1; bus.op = OP_MULT; bus.A = 32'd6; bus.B = 32'd7;
    @(negedge clk);
    sb_q.push_back('{"divu_queued", 32'd2, 32'd14});
    bus.op = OP_DIVU; bus.A = 32'd100; bus.B = 32'd7; bus.hilo_read = 1'b1;
    cycles   = 1;
    stall_ok = 1'b1;
    while (bus.done !== 1'b1 && cycles < 60) begin
      if (bus.stall !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
      cycles++;
    end
    check("held_stall_while_busy", {63'd0, stall_ok}, 64'd1);
    check("held_first_latency", 64'(cycles), 64'd34);
    check("held_stall_in_done", {63'd0, bus.stall}, 64'd0);
    @(negedge clk);
    bus.start = 1'b0; bus.op = OP_NOP; bus.hilo_read = 1'b0;
    check("held_second_accepted", {63'd0, bus.busy}, 64'd1);
    cycles = 1;
    while (bus.done !== 1'b1 && cycles < 60) begin
      @(negedge clk);
      cycles++;
    end
    check("held_second_latency", 64'(cycles), 64'd34);
    @(negedge clk);

    // Reset in the middle of a DIV.
    move_to(OP_MTHI, 32'hAAAA);
    check("mthi_write", {32'd0, bus.hi}, 64'hAAAA);
    bus.start = 1'b1; bus.op = OP_DIV; bus.A = 32'd1000; bus.B = 32'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.op = OP_NOP;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", {63'd0, bus.busy}, 64'd0);
    check("midrst_hi",   {32'd0, bus.hi}, 64'd0);
    check("midrst_lo",   {32'd0, bus.lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_still_idle", {63'd0, bus.busy}, 64'd0);

    // Flush during RUN and flush-over-start in IDLE.
    move_to(OP_MTHI, 32'h1234);
    move_to(OP_MTLO, 32'h1234);
    check("mt_hi", {32'd0, bus.hi}, 64'h1234);
    check("mt_lo", {32'd0, bus.lo}, 64'h1234);
    check("mt_no_busy", {63'd0, bus.busy}, 64'd0);
    bus.start = 1'b1; bus.op = OP_MULT; bus.A = 32'd3; bus.B = 32'd4;
    @(negedge clk);
    bus.start = 1'b0; bus.op = OP_NOP;
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", {63'd0, bus.busy}, 64'd0);
    check("flush_hi",   {32'd0, bus.hi}, 64'h1234);
    check("flush_lo",   {32'd0, bus.lo}, 64'h1234);
    repeat (40) @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MTHI; bus.A = 32'h5555; bus.flush = 1'b1;
    @(negedge clk);
    check("flush_blocks_mthi", {32'd0, bus.hi}, 64'h1234);
    bus.op = OP_MULTU;
    @(negedge clk);
    check("flush_blocks_start", {63'd0, bus.busy}, 64'd0);
    bus.start = 1'b0; bus.op = OP_NOP; bus.flush = 1'b0;
    repeat (40) @(negedge clk);
    check("flush_lo_kept", {32'd0, bus.lo}, 64'h1234);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
